sc_fifo: RTL
============

SC_FIFO -- requirements
Module: sc_fifo

Interface
REQ-001 The block SHALL use one clock, CLOCK; reset is synchronous and active-high, RESET.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 Parameter DEPTH_LOG2, default 4: log2 of storage depth; DEPTH = 2**DEPTH_LOG2, default 16.
REQ-004 Parameter AF_THRESH, default DEPTH-2: ALMOST_FULL asserts when COUNT >= AF_THRESH.
REQ-005 Parameter AE_THRESH, default 2: ALMOST_EMPTY asserts when COUNT <= AE_THRESH.
REQ-006 CLOCK  in  1  rising-edge clock for all state.
REQ-007 RESET  in  1  synchronous active-high reset.
REQ-008 DATA  in  WIDTH  write data.
REQ-009 WE  in  1  write request.
REQ-010 RE  in  1  read request.
REQ-011 FLUSH  in  1  synchronous empty command.
REQ-012 Q  out  WIDTH  registered read data.
REQ-013 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  1 each  registered status flags.
REQ-014 COUNT  out  DEPTH_LOG2+1  registered occupancy, 0..DEPTH.
REQ-015 OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-016 rd_ok = RE && !EMPTY; wr_ok = WE && (!FULL || rd_ok); both evaluated on pre-edge state.
REQ-017 On wr_ok, DATA SHALL be written at the write pointer and the write pointer incremented modulo DEPTH.
REQ-018 On rd_ok, Q SHALL load the word at the read pointer at that edge (read latency 1 cycle after RE sampled); read pointer increments modulo DEPTH.
REQ-019 Q SHALL hold its value on every cycle without rd_ok.
REQ-020 COUNT SHALL increment on wr_ok only, decrement on rd_ok only, hold when both or neither.
REQ-021 Flags SHALL be registered and reflect post-edge COUNT: FULL = (COUNT==DEPTH), EMPTY = (COUNT==0), ALMOST_FULL and ALMOST_EMPTY per REQ-004/005.
REQ-022 Full with WE and RE both asserted: both accepted, COUNT stays DEPTH, FULL stays 1.
REQ-023 Empty with WE and RE both asserted: write accepted, read rejected, COUNT becomes 1, Q unchanged, UNDERFLOW set.
REQ-024 WE && !wr_ok SHALL set OVERFLOW; DATA discarded, no state change besides the flag.
REQ-025 RE && EMPTY SHALL set UNDERFLOW; pointers, COUNT and Q unchanged.
REQ-026 OVERFLOW and UNDERFLOW SHALL remain set until RESET or FLUSH.
REQ-027 FLUSH (when RESET low) SHALL zero both pointers and COUNT, set EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, clear OVERFLOW/UNDERFLOW, hold Q, and ignore WE/RE in that cycle.
REQ-028 Priority: RESET > FLUSH > WE/RE.
REQ-029 Pointer wrap SHALL be seamless: data order preserved across any number of wraps.
REQ-030 Legal parameters: DEPTH_LOG2 >= 1, 1 <= AE_THRESH < AF_THRESH <= DEPTH; other values are unsupported.
REQ-031 Storage SHALL infer as memory without reset; contents are undefined after reset and never observable through Q before being written.

Reset
REQ-032 At the rising edge with RESET=1: pointers 0, COUNT 0, Q 0, EMPTY 1, ALMOST_EMPTY 1, FULL 0, ALMOST_FULL 0, OVERFLOW 0, UNDERFLOW 0.
REQ-033 RESET asserted mid-operation SHALL discard all stored words and override WE, RE and FLUSH in that cycle.

Verification (defaults WIDTH=8, DEPTH=16, AF=14, AE=2)
REQ-034 Reset; write AA,BB,CC,DD,EE; then RE held 7 cycles -> Q = AA..EE on the cycle after each accepted read, EMPTY=1 after fifth read, UNDERFLOW=1 on sixth, Q holds EE.
REQ-035 Write 16 words 00..0F -> ALMOST_FULL=1 at COUNT 14, FULL=1 at 16; 17th write -> OVERFLOW=1, COUNT 16; read all -> 00..0F in order, ALMOST_EMPTY=1 at COUNT 2.
REQ-036 FIFO full, WE+RE together for 20 cycles with incrementing data -> COUNT stays 16, read stream continuous and in order across pointer wrap.
REQ-037 FIFO empty, WE=1 DATA=5A with RE=1 -> COUNT 1, UNDERFLOW=1, Q unchanged; next read -> Q=5A.
REQ-038 Three words stored, FLUSH with WE=1 DATA=77 -> COUNT 0, EMPTY 1, flags cleared, 77 not stored; then write 11, read -> Q=11.
REQ-039 Write 11,22,33,44,55, assert RESET one cycle with WE/RE/FLUSH high -> all outputs equal REQ-032 values next cycle; subsequent RE -> UNDERFLOW=1, Q=00.

Source files
------------

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock synchronous FIFO with registered read data,
// registered status flags, an occupancy count and sticky error flags.
//
// Handshake: WE and RE are requests sampled at the rising CLOCK edge. A read
// is accepted when the FIFO is not empty. A write is accepted when the FIFO
// is not full, or when it is full and a read is accepted in the same cycle.
// An accepted read loads Q at that edge, so data appears one cycle after RE.
// A rejected write sets OVERFLOW and a rejected read sets UNDERFLOW. Both
// flags stay set until RESET or FLUSH. FLUSH empties the FIFO, keeps Q, and
// overrides WE and RE. RESET overrides everything else.
module sc_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic [WIDTH-1:0]      DATA,
   input  logic                  WE,
   input  logic                  RE,
   input  logic                  FLUSH,
   output logic [WIDTH-1:0]      Q,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   // Storage has no reset; words can only reach Q after they have been written.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [WIDTH-1:0] q_q,      q_d;
   logic             full_q,   full_d;
   logic             empty_q,  empty_d;
   logic             af_q,     af_d;
   logic             ae_q,     ae_d;
   logic             ovf_q,    ovf_d;
   logic             udf_q,    udf_d;

   logic             rd_ok;
   logic             wr_ok;

   // Acceptance is decided from the flags as they stand before the edge.
   assign rd_ok = RE && !empty_q;
   assign wr_ok = WE && (!full_q || rd_ok);

   // Next-state logic for pointers, occupancy, read data and flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      q_d      = q_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            q_d      = mem[rd_ptr_q];
         end
         if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
         end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
         end
         if (WE && !wr_ok) begin
            ovf_d = 1'b1;
         end
         if (RE && empty_q) begin
            udf_d = 1'b1;
         end
      end

      // Status flags track the occupancy after this edge.
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AF_C);
      ae_d    = (count_d <= AE_C);
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         q_q      <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         q_q      <= q_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage write port; reset and flush suppress the write.
   always_ff @(posedge CLOCK) begin
      if (!RESET && !FLUSH && wr_ok) begin
         mem[wr_ptr_q] <= DATA;
      end
   end

   assign Q            = q_q;
   assign FULL         = full_q;
   assign EMPTY        = empty_q;
   assign ALMOST_FULL  = af_q;
   assign ALMOST_EMPTY = ae_q;
   assign COUNT        = count_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule
